// File: rtl/d_sa_cache_ctrl_param.sv
// d_sa_cache_ctrl_param: parametrised set-associative L1 data-cache controller.
// Write-through, no-write-allocate, byte-enabled stores. On a read miss the
// victim is the first invalid way, else a per-set round-robin pointer.
// Optional feature: define DCACHE_FLUSH_EN to add a 'flush' input that clears
// every valid bit and victim pointer in one IDLE cycle.
module d_sa_cache_ctrl_param #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
`ifdef DCACHE_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_be,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data,
  output logic                     busy
);

  localparam int WSEL_W  = $clog2(LINE_WORDS);
  localparam int OFF_W   = WSEL_W + 2;
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W   = $clog2(NUM_WAYS);
  localparam int LINE_W  = 32 * LINE_WORDS;
  localparam int ENTRIES = NUM_SETS * NUM_WAYS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD_MISS_REQ,
    S_RD_MISS_WAIT,
    S_WR_REQ,
    S_RESP
  } state_t;

  // Control state (reset)
  state_t                            state_q, state_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0][WAY_W-1:0]    ptr_q, ptr_d;
  logic                              resp_valid_q, resp_valid_d;
  logic [31:0]                       resp_rdata_q, resp_rdata_d;
  logic                              mem_req_valid_q, mem_req_valid_d;
  logic                              mem_req_we_q, mem_req_we_d;
  logic [ADDR_W-1:0]                 mem_req_addr_q, mem_req_addr_d;
  logic [31:0]                       mem_wdata_q, mem_wdata_d;
  logic [3:0]                        mem_be_q, mem_be_d;

  // Captured request and victim choice (not reset)
  logic [ADDR_W-1:2]                 addr_q, addr_d;
  logic                              we_q, we_d;
  logic [31:0]                       wdata_q, wdata_d;
  logic [3:0]                        be_q, be_d;
  logic [WAY_W-1:0]                  victim_q, victim_d;
  logic                              set_full_q, set_full_d;

  // Tag and data arrays, addressed by {set, way}
  logic [TAG_W-1:0]                  tag_mem  [ENTRIES];
  logic [LINE_W-1:0]                 data_mem [ENTRIES];

  // The two byte-offset bits never matter: loads and stores are word-sized.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];

  logic flush_req;
`ifdef DCACHE_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  logic [TAG_W-1:0]  tag_f;
  logic [IDX_W-1:0]  idx_f;
  logic [WSEL_W-1:0] wsel_f;
  assign tag_f  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_f  = addr_q[OFF_W +: IDX_W];
  assign wsel_f = addr_q[2 +: WSEL_W];

  assign req_ready     = (state_q == S_IDLE) && !flush_req;
  assign busy          = (state_q != S_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;

  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_any;
  logic [WAY_W-1:0]    inv_way;

  // Tag compare across the set; descending loop leaves the lowest invalid way
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx_f][w] && (tag_mem[{idx_f, WAY_W'(w)}] == tag_f)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
      if (!valid_q[idx_f][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    hit_any = |hit_vec;
  end

  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged_line;
  logic [31:0]       hit_word;
  logic [31:0]       refill_word;

  // Word select from the hit line and byte-merge of store data into it
  always_comb begin
    hit_line    = data_mem[{idx_f, hit_way}];
    hit_word    = hit_line[32*int'(wsel_f) +: 32];
    refill_word = mem_resp_data[32*int'(wsel_f) +: 32];
    merged_line = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) begin
        merged_line[32*int'(wsel_f) + 8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  logic              arr_we;
  logic [WAY_W-1:0]  arr_way;
  logic [LINE_W-1:0] arr_line;

  // Single array write port: store-hit merge or refill of the victim way
  always_comb begin
    arr_we   = 1'b0;
    arr_way  = hit_way;
    arr_line = merged_line;
    if (state_q == S_LOOKUP && we_q && hit_any) begin
      arr_we = 1'b1;
    end else if (state_q == S_RD_MISS_WAIT && mem_resp_valid) begin
      arr_we   = 1'b1;
      arr_way  = victim_q;
      arr_line = mem_resp_data;
    end
  end

  // Tag/data array update (contents are don't-care until the valid bit is set)
  always_ff @(posedge clk) begin
    if (reset_n && arr_we) begin
      tag_mem[{idx_f, arr_way}]  <= tag_f;
      data_mem[{idx_f, arr_way}] <= arr_line;
    end
  end

  // Next-state, valid/pointer updates and registered outputs
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    ptr_d           = ptr_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    be_d            = be_q;
    victim_d        = victim_q;
    set_full_d      = set_full_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          valid_d = '0;
          ptr_d   = '0;
        end else if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:2];
          we_d    = req_we;
          wdata_d = req_wdata;
          be_d    = req_be;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (we_q) begin
          mem_req_valid_d = 1'b1;
          mem_req_we_d    = 1'b1;
          mem_req_addr_d  = {addr_q, 2'b00};
          mem_wdata_d     = wdata_q;
          mem_be_d        = be_q;
          state_d         = S_WR_REQ;
        end else if (hit_any) begin
          resp_rdata_d = hit_word;
          state_d      = S_RESP;
        end else begin
          victim_d        = inv_any ? inv_way : ptr_q[idx_f];
          set_full_d      = !inv_any;
          mem_req_valid_d = 1'b1;
          mem_req_we_d    = 1'b0;
          mem_req_addr_d  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d         = S_RD_MISS_REQ;
        end
      end
      S_RD_MISS_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_RD_MISS_WAIT;
        end
      end
      S_RD_MISS_WAIT: begin
        if (mem_resp_valid) begin
          valid_d[idx_f][victim_q] = 1'b1;
          if (set_full_q) begin
            ptr_d[idx_f] = victim_q + WAY_W'(1);
          end
          resp_rdata_d = refill_word;
          state_d      = S_RESP;
        end
      end
      S_WR_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          resp_rdata_d    = 32'h0;
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      valid_q         <= '0;
      ptr_q           <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'h0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_wdata_q     <= 32'h0;
      mem_be_q        <= 4'h0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      ptr_q           <= ptr_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
    end
  end

  // Request capture and victim choice carry no reset
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    we_q       <= we_d;
    wdata_q    <= wdata_d;
    be_q       <= be_d;
    victim_q   <= victim_d;
    set_full_q <= set_full_d;
  end

  // A line may live in at most one way of its set
  always_ff @(posedge clk) begin
    if (reset_n && state_q == S_LOOKUP) begin
      assert ($onehot0(hit_vec));
    end
  end

endmodule

// File: tb/tb_d_sa_cache_ctrl_param.sv
// tb_d_sa_cache_ctrl_param: directed and randomized bench for the L1 D-cache
// controller, with a behavioural cache/memory model and a per-cycle checker.
module tb_d_sa_cache_ctrl_param;

  localparam int ADDR_W     = 32;
  localparam int NUM_SETS   = 4;
  localparam int NUM_WAYS   = 4;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = 32 * LINE_WORDS;
  localparam int LINE_BYTES = 4 * LINE_WORDS;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
`ifdef DCACHE_FLUSH_EN
  logic              flush = 1'b0;
`endif
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic [3:0]        req_be = 4'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_resp_valid = 1'b0;
  logic [LINE_W-1:0] mem_resp_data = '0;
  logic              busy;

  d_sa_cache_ctrl_param #(
    .ADDR_W(ADDR_W), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef DCACHE_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: backing memory plus which tags each set holds
  logic [31:0] mem [logic [31:0]];
  bit          mv   [NUM_SETS][NUM_WAYS];
  int          mtag [NUM_SETS][NUM_WAYS];
  int          mptr [NUM_SETS];

  // Expectations shared with the checker
  bit          exp_mem_pend = 0;
  bit          exp_mem_we = 0;
  logic [31:0] exp_mem_addr = 0;
  logic [31:0] exp_mem_wdata = 0;
  logic [3:0]  exp_mem_be = 0;
  bit          exp_resp_pend = 0;
  logic [31:0] exp_rdata = 0;
  bit          exp_hit_load = 0;
  int          accept_cyc = 0;
  logic [31:0] last_rd_addr = 0;
  logic [31:0] last_wr_addr = 0;
  logic [3:0]  last_wr_be = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_WORDS; w++) l[32*w +: 32] = mem_rd(base + 32'(4*w));
    return l;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % NUM_SETS);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'(a / (LINE_BYTES * NUM_SETS));
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NUM_SETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < NUM_WAYS; w++) mv[s][w] = 0;
    end
  endfunction

  // Per-cycle checker of everything the DUT drives when it is meaningful
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_req_valid) begin
        check("mem_req_expected", 32'(exp_mem_pend), 32'd1);
        if (exp_mem_pend) begin
          check("mem_req_we", 32'(mem_req_we), 32'(exp_mem_we));
          check("mem_req_addr", mem_req_addr, exp_mem_addr);
          if (exp_mem_we) begin
            check("mem_wdata", mem_wdata, exp_mem_wdata);
            check("mem_be", 32'(mem_be), 32'(exp_mem_be));
          end
          check("busy_in_mem_req", 32'(busy), 32'd1);
          check("req_ready_in_mem_req", 32'(req_ready), 32'd0);
        end
      end
      if (resp_valid) begin
        check("resp_expected", 32'(exp_resp_pend), 32'd1);
        if (exp_resp_pend) begin
          check("resp_rdata", resp_rdata, exp_rdata);
          if (exp_hit_load) check("hit_latency", 32'(cyc - accept_cyc), 32'd2);
        end
      end
    end
  end

  // One core request end to end; the bench also plays the memory side
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall,
                        output logic [31:0] rdata, output bit did_rd, output int lat);
    int s, t, vw, budget, stall_left, rdelay;
    bit hit, done, rd_pend, hs, hs_we;
    logic [31:0] line_base, wa, old, hs_addr;
    logic [3:0] hs_be;
    s = set_of(addr); t = tag_of(addr);
    wa = {addr[31:2], 2'b00};
    line_base = addr & ~32'(LINE_BYTES - 1);
    hit = 0;
    for (int w = 0; w < NUM_WAYS; w++) if (mv[s][w] && mtag[s][w] == t) hit = 1;
    exp_resp_pend = 1;
    exp_hit_load = !we && hit;
    exp_mem_wdata = wdata;
    exp_mem_be = be;
    if (we) begin
      exp_mem_pend = 1; exp_mem_we = 1; exp_mem_addr = wa; exp_rdata = 32'h0;
      old = mem_rd(wa);
      for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wdata[8*b +: 8];
      mem[wa] = old;
    end else begin
      exp_rdata = mem_rd(wa);
      exp_mem_pend = !hit; exp_mem_we = 0; exp_mem_addr = line_base;
      if (!hit) begin
        vw = -1;
        for (int w = 0; w < NUM_WAYS; w++) if (!mv[s][w] && vw < 0) vw = w;
        if (vw < 0) begin vw = mptr[s]; mptr[s] = (mptr[s] + 1) % NUM_WAYS; end
        mv[s][vw] = 1; mtag[s][vw] = t;
      end
    end
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 50) begin @(negedge clk); budget++; end
    if (!req_ready) begin tests++; fails++; $display("FAIL accept_timeout: req_ready stayed 0"); end
    @(posedge clk); #1;
    accept_cyc = cyc; req_valid = 0;
    done = 0; rd_pend = 0; rdelay = 0; did_rd = 0; budget = 0; stall_left = stall;
    rdata = 32'h0; lat = 0;
    while (!done && budget < 300) begin
      mem_req_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      mem_resp_valid = 0;
      if (rd_pend) begin
        if (rdelay == 0) begin mem_resp_valid = 1; mem_resp_data = line_of(line_base); rd_pend = 0; end
        else rdelay--;
      end
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready; hs_we = mem_req_we; hs_addr = mem_req_addr; hs_be = mem_be;
      if (mem_req_valid && stall_left > 0) stall_left--;
      if (resp_valid) begin done = 1; rdata = resp_rdata; lat = cyc - accept_cyc; end
      @(posedge clk); #1;
      if (hs) begin
        exp_mem_pend = 0;
        if (hs_we) begin last_wr_addr = hs_addr; last_wr_be = hs_be; end
        else begin did_rd = 1; last_rd_addr = hs_addr; rd_pend = 1; rdelay = $urandom_range(0, 3); end
      end
      budget++;
    end
    if (!done) begin tests++; fails++; $display("FAIL resp_timeout: no resp_valid for addr %h", addr); end
    check("expected_mem_req_seen", 32'(exp_mem_pend), 32'd0);
    exp_resp_pend = 0; exp_mem_pend = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
  endtask

  // Load miss aborted by reset while waiting for the refill
  task automatic do_abort(input logic [31:0] addr);
    int budget;
    bit saw, hs;
    logic [31:0] line_base;
    line_base = addr & ~32'(LINE_BYTES - 1);
    exp_mem_pend = 1; exp_mem_we = 0; exp_mem_addr = line_base;
    exp_resp_pend = 0; exp_hit_load = 0;
    req_valid = 1; req_we = 0; req_addr = addr; mem_req_ready = 1;
    @(posedge clk); #1;
    req_valid = 0;
    budget = 0; hs = 0;
    while (!hs && budget < 20) begin
      @(negedge clk); hs = mem_req_valid && mem_req_ready;
      @(posedge clk); #1; budget++;
    end
    check("abort_mem_req_seen", 32'(hs), 32'd1);
    exp_mem_pend = 0; mem_req_ready = 0;
    @(posedge clk); #1;
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    model_clear();
    mem_resp_valid = 1; mem_resp_data = line_of(line_base);
    @(posedge clk); #1;
    mem_resp_valid = 0;
    saw = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) saw = 1; @(posedge clk); #1; end
    check("abort_no_resp", 32'(saw), 32'd0);
    @(negedge clk);
    check("abort_resp_rdata_reset", resp_rdata, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  bit          did;
  int          lat;

  initial begin
    logic [31:0] a;
    bit          rwe;
    model_clear();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_req_we", 32'(mem_req_we), 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    mem[32'h40] = 32'h11; mem[32'h44] = 32'h22; mem[32'h48] = 32'h33; mem[32'h4C] = 32'h44;
    do_req(0, 32'h40, 0, 0, 0, rd, did, lat);
    check("t1_load40_rdata", rd, 32'h11);
    check("t1_load40_miss", 32'(did), 32'd1);
    check("t1_line_addr", last_rd_addr, 32'h40);
    do_req(0, 32'h48, 0, 0, 0, rd, did, lat);
    check("t1_load48_rdata", rd, 32'h33);
    check("t1_load48_hit", 32'(did), 32'd0);
    check("t1_load48_latency", 32'(lat), 32'd2);

    do_req(1, 32'h44, 32'hDEADBEEF, 4'b0011, 0, rd, did, lat);
    check("t2_store_addr", last_wr_addr, 32'h44);
    check("t2_store_be", 32'(last_wr_be), 32'h3);
    check("t2_store_rdata", rd, 32'h0);
    do_req(0, 32'h44, 0, 0, 0, rd, did, lat);
    check("t2_load44_merged", rd, 32'h0000BEEF);
    check("t2_load44_hit", 32'(did), 32'd0);
    do_req(1, 32'h80, 32'h12345678, 4'b1111, 0, rd, did, lat);
    check("t2_store80_addr", last_wr_addr, 32'h80);
    do_req(0, 32'h80, 0, 0, 0, rd, did, lat);
    check("t2_load80_miss", 32'(did), 32'd1);
    check("t2_load80_rdata", rd, 32'h12345678);

    do_req(0, 32'hC0, 0, 0, 0, rd, did, lat);
    do_req(0, 32'h100, 0, 0, 0, rd, did, lat);
    do_req(0, 32'h140, 0, 0, 0, rd, did, lat);
    check("t3_tag5_miss", 32'(did), 32'd1);
    do_req(0, 32'h80, 0, 0, 0, rd, did, lat);
    check("t3_way1_kept", 32'(did), 32'd0);
    do_req(0, 32'h180, 0, 0, 0, rd, did, lat);
    check("t3_tag6_miss", 32'(did), 32'd1);
    do_req(0, 32'h100, 0, 0, 0, rd, did, lat);
    check("t3_tag4_hit", 32'(did), 32'd0);
    do_req(0, 32'hC0, 0, 0, 0, rd, did, lat);
    check("t3_tag3_hit", 32'(did), 32'd0);
    do_req(0, 32'h80, 0, 0, 0, rd, did, lat);
    check("t3_tag2_evicted", 32'(did), 32'd1);

    do_req(0, 32'h200, 0, 0, 5, rd, did, lat);
    check("t4_stall_miss", 32'(did), 32'd1);

    do_abort(32'h240);
    do_req(0, 32'h48, 0, 0, 0, rd, did, lat);
    check("t5_after_reset_miss", 32'(did), 32'd1);
    check("t5_after_reset_rdata", rd, 32'h33);

`ifdef DCACHE_FLUSH_EN
    do_req(0, 32'h40, 0, 0, 0, rd, did, lat);
    flush = 1; req_valid = 1; req_we = 0; req_addr = 32'h40;
    @(negedge clk);
    check("t6_flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    @(negedge clk);
    check("t6_flush_not_accepted", 32'(busy), 32'd0);
    @(posedge clk); #1;
    model_clear();
    do_req(0, 32'h40, 0, 0, 0, rd, did, lat);
    check("t6_after_flush_miss", 32'(did), 32'd1);
`endif

    for (int i = 0; i < 200; i++) begin
      rwe = ($urandom_range(0, 2) == 0);
      a = (32'($urandom_range(1, 6)) << 6) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      do_req(rwe, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), rd, did, lat);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/d_sa_cache_ctrl_param.md
Name: d_sa_cache_ctrl_param

Overview:
- Parametrised set-associative L1 data-cache controller. Holds the tag, valid and data arrays and does its own lookup.
- Sits between the core load/store unit and the memory interface. Uses valid/ready handshakes on both sides.
- Policy: write-through, no-write-allocate, byte-enabled stores.
- Replacement: first invalid way, otherwise a per-set round-robin victim pointer.

Parameters:
- ADDR_W, 32, byte address width.
- NUM_SETS, 4, number of sets (power of 2, ≥2).
- NUM_WAYS, 4, ways per set (power of 2, ≥2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- Derived widths:
  - OFF_W = log2(LINE_WORDS) + 2
  - IDX_W = log2(NUM_SETS)
  - TAG_W = ADDR_W − IDX_W − OFF_W

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data
- req_be  in  4  store byte enables
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load data (0 for stores)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  1 = word write, 0 = line read
- mem_req_addr  out  ADDR_W  line-aligned address for reads; word-aligned address for writes
- mem_wdata  out  32  write data
- mem_be  out  4  write byte enables
- mem_resp_valid  in  1  refill line valid
- mem_resp_data  in  32*LINE_WORDS  refill line (word 0 in the LSBs)
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset is synchronous on clk, active-low reset_n. On reset:
  - state = IDLE; all valid bits = 0; all victim pointers = 0.
  - resp_valid = 0, resp_rdata = 0.
  - mem_req_valid = 0, mem_req_we = 0, mem_req_addr = 0, mem_wdata = 0, mem_be = 0.
  - Tag and data arrays are not reset.
- Reset mid-operation aborts immediately. A pending memory request is dropped and any later mem_resp_valid is ignored.
- Request accept: req_valid && req_ready at edge T. Address, we, wdata and be are captured into q registers.
- States: IDLE, LOOKUP, RD_MISS_REQ, RD_MISS_WAIT, WR_REQ, RESP.
- IDLE → LOOKUP on accept.
- LOOKUP: hit = any way in set idx_q with valid && tag == tag_q. Exactly one way may match; a multiple match is an assertion failure.
  - Read hit: resp_rdata ← selected word → RESP. Load latency from accept edge to resp_valid is 2 cycles.
  - Read miss: pick the victim, which is the lowest-index invalid way, else victim_ptr[idx_q] → RD_MISS_REQ.
  - Store (hit or miss): on a hit, merge the bytes where be_q = 1 into the hit way's word → WR_REQ. A miss leaves the cache untouched.
- RD_MISS_REQ: mem_req_valid = 1, mem_req_we = 0, mem_req_addr = {tag_q, idx_q, OFF_W'b0}. Held stable until mem_req_ready, then → RD_MISS_WAIT.
- RD_MISS_WAIT: on mem_resp_valid:
  - Write the line, tag and valid = 1 into the victim way.
  - If the set was full, victim_ptr[idx_q] ← victim + 1, wrapping at NUM_WAYS. Otherwise the pointer is unchanged.
  - resp_rdata ← word off_q of mem_resp_data → RESP.
- WR_REQ: mem_req_valid = 1, mem_req_we = 1, mem_req_addr = {addr_q[ADDR_W−1:2], 2'b00}, mem_wdata = wdata_q, mem_be = be_q. Held until mem_req_ready, then → RESP with resp_rdata = 0.
- RESP: resp_valid = 1 for exactly one cycle → IDLE. The next request may be accepted the cycle after RESP.
- mem_req_valid deasserts the cycle after a handshake.
- mem_resp_valid outside RD_MISS_WAIT is ignored.
- be_q = 0 on a store: the cache is unchanged, but the memory write is still issued with be = 0.

Optional Feature:
- Macro: DCACHE_FLUSH_EN.
- When defined, a 1-bit input flush is added. flush sampled high in IDLE clears all valid bits and all victim pointers in one cycle.
- Flush has priority over a simultaneous req_valid: req_ready = 0 that cycle.
- flush outside IDLE is ignored.
- When undefined, there is no flush port and lines are invalidated only by reset.

Test Plan:
- Reset → load 0x0000_0040: miss, memory line read at 0x40; refill {0x44,0x33,0x22,0x11} → resp_rdata = 0x11. Reloading 0x48 hits → resp_rdata = 0x33, 2 cycles after accept, with no memory request.
- Store 0xDEAD_BEEF be = 4'b0011 to 0x44 after that fill → memory write at 0x44 be = 0011; load 0x44 returns 0x0000_BEEF. A store to an uncached 0x80 writes memory only, and a load of 0x80 then misses.
- Fill all 4 ways of set 0 (tags 1..4), then miss on tag 5 → way 0 replaced, pointer = 1; miss on tag 6 → way 1 replaced.
- Hold mem_req_ready low for 5 cycles → mem_req_valid and mem_req_addr stay stable, req_ready = 0, busy = 1 throughout.
- Assert reset_n = 0 during RD_MISS_WAIT, then deliver mem_resp_valid → no response, all lines invalid, and the next load misses.
- DCACHE_FLUSH_EN: fill 0x40, pulse flush together with req_valid → req not accepted that cycle; the next load of 0x40 misses.
